// File: rtl/cache_req_controller.sv
// rtl/cache_req_controller.sv - request-side sequencer for the cache storage array
//
// Purpose: accepts GET/PUT/DEL commands, drives the array lookup, picks the
// target entry (matching entry or lowest free entry), issues one write or
// delete strobe, returns a status/value response and keeps occupancy and
// saturating hit/miss statistics.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             command handshake
//   req_op/req_key/req_value        command (00 GET, 01 PUT, 10 DEL, 11 reserved)
//   rsp_valid/rsp_ready             response handshake
//   rsp_status/rsp_value            00 OK, 01 NOT_FOUND, 10 FULL, 11 INVALID; GET data
//   mem_write/mem_delete            array strobes (only in WRITE)
//   mem_key/mem_value/mem_index     array key, data and one-hot target entry
//   mem_hit/mem_index_in/
//   mem_value_in                    registered lookup result from the array
//   mem_used_entries                per-entry used mask from the array
//   occupancy                       registered popcount of mem_used_entries
//   hit_count/miss_count            saturating GET/DEL hit and miss counters

module cache_req_controller #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 32,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_op,
  input  logic [KEY_WIDTH-1:0]               req_key,
  input  logic [VALUE_WIDTH-1:0]             req_value,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [1:0]                         rsp_status,
  output logic [VALUE_WIDTH-1:0]             rsp_value,
  output logic                               mem_write,
  output logic                               mem_delete,
  output logic [KEY_WIDTH-1:0]               mem_key,
  output logic [VALUE_WIDTH-1:0]             mem_value,
  output logic [NUM_ENTRIES-1:0]             mem_index,
  input  logic                               mem_hit,
  input  logic [NUM_ENTRIES-1:0]             mem_index_in,
  input  logic [VALUE_WIDTH-1:0]             mem_value_in,
  input  logic [NUM_ENTRIES-1:0]             mem_used_entries,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy,
  output logic [STAT_WIDTH-1:0]              hit_count,
  output logic [STAT_WIDTH-1:0]              miss_count
);

  localparam int OCC_W = $clog2(NUM_ENTRIES+1);

  localparam logic [1:0] OP_GET = 2'b00;
  localparam logic [1:0] OP_PUT = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_NOT_FOUND = 2'b01;
  localparam logic [1:0] ST_FULL      = 2'b10;
  localparam logic [1:0] ST_INVALID   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_EVAL   = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                   r_state;
  logic [1:0]               r_op;
  logic [VALUE_WIDTH-1:0]   r_value;
  logic                     r_req_ready;
  logic                     r_rsp_valid;
  logic [1:0]               r_rsp_status;
  logic [VALUE_WIDTH-1:0]   r_rsp_value;
  logic                     r_mem_write;
  logic                     r_mem_delete;
  logic [KEY_WIDTH-1:0]     r_mem_key;
  logic [VALUE_WIDTH-1:0]   r_mem_value;
  logic [NUM_ENTRIES-1:0]   r_mem_index;
  logic [OCC_W-1:0]         r_occupancy;
  logic [STAT_WIDTH-1:0]    r_hit_count;
  logic [STAT_WIDTH-1:0]    r_miss_count;

  logic [NUM_ENTRIES-1:0]   w_free_onehot;
  logic                     w_has_free;
  logic [OCC_W-1:0]         w_popcount;

  // Lowest-index free entry: scan from the top so the lowest zero bit wins.
  always_comb begin
    w_free_onehot = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (!mem_used_entries[i]) begin
        w_free_onehot    = '0;
        w_free_onehot[i] = 1'b1;
      end
    end
    w_has_free = ~(&mem_used_entries);
  end

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_popcount = w_popcount + OCC_W'(mem_used_entries[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occupancy <= '0;
    end else begin
      r_occupancy <= w_popcount;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= OP_GET;
      r_value      <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
      r_rsp_value  <= '0;
      r_mem_write  <= 1'b0;
      r_mem_delete <= 1'b0;
      r_mem_key    <= '0;
      r_mem_value  <= '0;
      r_mem_index  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_value     <= req_value;
            r_req_ready <= 1'b0;
            if (req_op == OP_RSV || req_key == '0) begin
              // Rejected without touching the array; mem_key stays 0.
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_INVALID;
              r_rsp_value  <= '0;
              r_state      <= S_RESP;
            end else begin
              r_mem_key <= req_key;
              r_state   <= S_LOOKUP;
            end
          end
        end

        // The array registers its compare at the end of this cycle.
        S_LOOKUP: begin
          r_state <= S_EVAL;
        end

        S_EVAL: begin
          case (r_op)
            OP_GET: begin
              r_rsp_valid <= 1'b1;
              r_mem_key   <= '0;
              r_state     <= S_RESP;
              if (mem_hit) begin
                r_rsp_status <= ST_OK;
                r_rsp_value  <= mem_value_in;
                if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
              end else begin
                r_rsp_status <= ST_NOT_FOUND;
                r_rsp_value  <= '0;
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
              end
            end
            OP_PUT: begin
              if (mem_hit || w_has_free) begin
                // Update in place on hit, otherwise claim the lowest free entry.
                r_mem_index <= mem_hit ? mem_index_in : w_free_onehot;
                r_mem_write <= 1'b1;
                r_mem_value <= r_value;
                r_state     <= S_WRITE;
              end else begin
                r_rsp_valid  <= 1'b1;
                r_rsp_status <= ST_FULL;
                r_rsp_value  <= '0;
                r_mem_key    <= '0;
                r_state      <= S_RESP;
              end
            end
            OP_DEL: begin
              r_mem_key <= '0;
              if (mem_hit) begin
                r_mem_index  <= mem_index_in;
                r_mem_delete <= 1'b1;
                r_mem_value  <= '0;
                r_state      <= S_WRITE;
                if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
              end else begin
                r_rsp_valid  <= 1'b1;
                r_rsp_status <= ST_NOT_FOUND;
                r_rsp_value  <= '0;
                r_state      <= S_RESP;
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
              end
            end
            default: begin
              // Reserved ops are filtered in IDLE; answer INVALID defensively.
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_INVALID;
              r_rsp_value  <= '0;
              r_mem_key    <= '0;
              r_state      <= S_RESP;
            end
          endcase
        end

        // Strobes last exactly one cycle; only writes get here, so status is OK.
        S_WRITE: begin
          r_mem_write  <= 1'b0;
          r_mem_delete <= 1'b0;
          r_mem_index  <= '0;
          r_mem_key    <= '0;
          r_mem_value  <= '0;
          r_rsp_valid  <= 1'b1;
          r_rsp_status <= ST_OK;
          r_rsp_value  <= '0;
          r_state      <= S_RESP;
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= ST_OK;
            r_rsp_value  <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;
  assign rsp_value  = r_rsp_value;
  assign mem_write  = r_mem_write;
  assign mem_delete = r_mem_delete;
  assign mem_key    = r_mem_key;
  assign mem_value  = r_mem_value;
  assign mem_index  = r_mem_index;
  assign occupancy  = r_occupancy;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: doc/cache_req_controller.md
Name: cache_req_controller

Overview:
- Request-side initiator for the cache storage array: accepts GET/PUT/DEL commands over a valid/ready interface and sequences the array's lookup, write and delete controls.
- Chooses free entries for inserts and returns a status/value response over a second valid/ready interface.
- Sits between the command front-end and the memory block. Also keeps occupancy and hit/miss statistics.

Parameters:
NUM_ENTRIES, 8, number of cache entries (width of one-hot index and used mask)
KEY_WIDTH, 16, key width; key 0 is reserved as "no key"
VALUE_WIDTH, 32, value width
STAT_WIDTH, 16, width of saturating hit/miss counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command valid
req_ready  output  1  controller can accept a command
req_op  input  2  00 GET, 01 PUT, 10 DEL, 11 reserved
req_key  input  KEY_WIDTH  command key
req_value  input  VALUE_WIDTH  PUT data
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_status  output  2  00 OK, 01 NOT_FOUND, 10 FULL, 11 INVALID
rsp_value  output  VALUE_WIDTH  GET data (0 unless GET with OK)
mem_write  output  1  array write strobe
mem_delete  output  1  array delete strobe
mem_key  output  KEY_WIDTH  key to array
mem_value  output  VALUE_WIDTH  value to array
mem_index  output  NUM_ENTRIES  one-hot target entry
mem_hit  input  1  registered hit from array
mem_index_in  input  NUM_ENTRIES  registered one-hot match index from array
mem_value_in  input  VALUE_WIDTH  registered value from array
mem_used_entries  input  NUM_ENTRIES  per-entry used mask
occupancy  output  $clog2(NUM_ENTRIES+1)  registered popcount of mem_used_entries
hit_count  output  STAT_WIDTH  saturating count of GET/DEL hits
miss_count  output  STAT_WIDTH  saturating count of GET/DEL misses

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low. Reset forces IDLE and sets every output to 0 except req_ready=1. A reset mid-operation drops the pending command with no response and no write.
- FSM states: IDLE, LOOKUP, EVAL, WRITE, RESP.
- IDLE:
  - req_ready=1 and mem_key=0, so the array reports no hit.
  - On req_valid&&req_ready, latch op, key and value.
  - If op==11 or key==0: go to RESP with INVALID; the array is not accessed.
  - Otherwise go to LOOKUP.
- LOOKUP (1 cycle):
  - mem_key = latched key; mem_write = mem_delete = 0.
  - The array registers its compare at the end of this cycle.
- EVAL (1 cycle):
  - Sample mem_hit, mem_index_in, mem_value_in and mem_used_entries. mem_key is held.
  - GET: hit → OK with rsp_value = mem_value_in; miss → NOT_FOUND. Go to RESP.
  - PUT: hit → target = mem_index_in (update in place). Miss with a free entry → target = lowest-index zero bit of mem_used_entries. Go to WRITE with status OK. Miss with all entries used → FULL, go to RESP, no write.
  - DEL: hit → target = mem_index_in, go to WRITE with status OK. Miss → NOT_FOUND, go to RESP.
- WRITE (exactly 1 cycle):
  - mem_index = target.
  - PUT: mem_write=1, mem_key/mem_value = latched.
  - DEL: mem_delete=1, mem_key/mem_value = 0.
  - Go to RESP.
- RESP:
  - rsp_valid=1; status and value held stable until rsp_valid&&rsp_ready, then go to IDLE.
  - req_ready=0 in every state except IDLE. One command outstanding at a time.
- mem_write, mem_delete and mem_index are 0 in every state other than WRITE; the strobes are never asserted together.
- Latency (with rsp_ready=1), acceptance at cycle T:
  - INVALID: rsp_valid at T+1.
  - GET, FULL, NOT_FOUND: rsp_valid at T+3.
  - PUT/DEL with write: rsp_valid at T+4.
  - Next acceptance: one cycle after the response handshake.
- Statistics:
  - GET/DEL hit increments hit_count in EVAL; GET/DEL miss increments miss_count.
  - PUT and INVALID commands are not counted.
  - Counters saturate at 2^STAT_WIDTH-1.
- occupancy is registered every cycle from mem_used_entries, so it is one cycle behind the mask.

Test Plan:
- Setup for all scenarios: NUM_ENTRIES=4, KEY_WIDTH=8, VALUE_WIDTH=8, connected to the memory block.
- Reset, then PUT key 0x11 value 0xAA → rsp OK at T+4. mem_write pulsed once with mem_index=0001. occupancy=1 one cycle after the write. GET 0x11 → OK, rsp_value=0xAA at T+3, hit_count=1.
- PUT keys 0x01..0x04 → mem_index 0001, 0010, 0100, 1000 in order. PUT 0x05 → FULL, no mem_write. PUT 0x02 value 0x77 → OK, writes index 0010, occupancy stays 4.
- DEL 0x03 → mem_delete with index 0100, OK, occupancy 3. Second DEL 0x03 → NOT_FOUND, miss_count+1. Next PUT 0x09 → reuses index 0100.
- req_op=11, or GET with key 0 → INVALID at T+1, no mem strobes, counters unchanged.
- Hold rsp_ready=0 for 5 cycles after GET → rsp_valid, status and value stable, req_ready=0. Release → handshake, IDLE, req_ready=1 next cycle.
- Assert rst_n=0 during the WRITE cycle → all outputs 0 (req_ready=1) immediately, no response issued. Preset the counter to max and issue a GET hit → hit_count stays at 0xFFFF.
